// File: rtl/mult3x2_pkg.sv
// Shared widths and limits for the 3x2 unsigned array multiplier.
package mult3x2_pkg;

    localparam int unsigned A_W   = 3;
    localparam int unsigned B_W   = 2;
    localparam int unsigned P_W   = A_W + B_W;
    localparam int unsigned P_MAX = 21;

endpackage : mult3x2_pkg

// File: rtl/full_adder_1b.sv
// One-bit full adder; tie cin to 0 to use it as a half adder.
// Ports:
//   a, b, cin : addend bits and carry-in
//   sum_c     : combinational sum bit
//   carry_c   : combinational carry-out
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_c,
    output logic carry_c
);

    logic ab_x;

    assign ab_x    = a ^ b;
    assign sum_c   = ab_x ^ cin;
    assign carry_c = (a & b) | (cin & ab_x);

endmodule : full_adder_1b

// File: rtl/multiplier_3x2.sv
// Registered unsigned 3-bit x 2-bit multiplier built from a two-row
// partial-product array with a ripple of half/full adders.
// Ports:
//   Clk          : rising-edge clock
//   Rst_n        : synchronous active-low reset
//   in_valid     : operands valid this cycle
//   multiplicand : unsigned operand A (0..7)
//   multiplier   : unsigned operand B (0..3)
//   product      : registered A*B (0..21), held when no new operands arrive
//   out_valid    : product was computed on the previous cycle
module multiplier_3x2
    import mult3x2_pkg::*;
(
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           in_valid,
    input  logic [A_W-1:0] multiplicand,
    input  logic [B_W-1:0] multiplier,
    output logic [P_W-1:0] product,
    output logic           out_valid
);

    // Partial products: row 0 uses b0, row 1 uses b1 (shifted one column).
    logic pp_a0b0, pp_a1b0, pp_a2b0;
    logic pp_a0b1, pp_a1b1, pp_a2b1;

    assign pp_a0b0 = multiplicand[0] & multiplier[0];
    assign pp_a1b0 = multiplicand[1] & multiplier[0];
    assign pp_a2b0 = multiplicand[2] & multiplier[0];
    assign pp_a0b1 = multiplicand[0] & multiplier[1];
    assign pp_a1b1 = multiplicand[1] & multiplier[1];
    assign pp_a2b1 = multiplicand[2] & multiplier[1];

    logic p1, p2, p3;
    logic c1, c2, c3;

    // Column 1: half adder.
    full_adder_1b u_ha_col1 (
        .a       (pp_a1b0),
        .b       (pp_a0b1),
        .cin     (1'b0),
        .sum_c   (p1),
        .carry_c (c1)
    );

    // Column 2: full adder absorbing the column-1 carry.
    full_adder_1b u_fa_col2 (
        .a       (pp_a2b0),
        .b       (pp_a1b1),
        .cin     (c1),
        .sum_c   (p2),
        .carry_c (c2)
    );

    // Column 3: half adder; its carry is the product MSB.
    full_adder_1b u_ha_col3 (
        .a       (pp_a2b1),
        .b       (c2),
        .cin     (1'b0),
        .sum_c   (p3),
        .carry_c (c3)
    );

    logic [P_W-1:0] product_c;

    assign product_c = {c3, p3, p2, p1, pp_a0b0};

    // Output stage: product only reloads on valid operands, otherwise holds.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                product <= product_c;
            end
        end
    end

endmodule : multiplier_3x2

// File: tb/tb_multiplier_3x2.sv
module tb_multiplier_3x2;
    import mult3x2_pkg::*;

    logic           Clk;
    logic           Rst_n;
    logic           in_valid;
    logic [A_W-1:0] multiplicand;
    logic [B_W-1:0] multiplier;
    logic [P_W-1:0] product;
    logic           out_valid;

    int checks;
    int errors;

    // Reference state: what the outputs must hold after each edge.
    int ref_product;
    int ref_valid;

    typedef struct {
        logic       rst_n;
        logic       v;
        int         a;
        int         b;
        int         p;
        int         ov;
        string      name;
    } vec_t;

    vec_t tbl[$];

    multiplier_3x2 dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .in_valid     (in_valid),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .out_valid    (out_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input int p_exp, input int ov_exp);
        checks++;
        if (product !== P_W'(p_exp) || out_valid !== 1'(ov_exp)) begin
            errors++;
            $display("FAIL %s: product=%0d out_valid=%0b, required product=%0d out_valid=%0d",
                     name, product, out_valid, p_exp, ov_exp);
        end
    endtask

    // Apply one cycle of inputs, advance the reference, sample #1 after the edge.
    task automatic step(input logic rst_n, input logic v, input int a, input int b);
        Rst_n        = rst_n;
        in_valid     = v;
        multiplicand = A_W'(a);
        multiplier   = B_W'(b);
        @(posedge Clk);
        #1;
        if (!rst_n) begin
            ref_product = 0;
            ref_valid   = 0;
        end else if (v) begin
            ref_product = a * b;
            ref_valid   = 1;
        end else begin
            ref_valid   = 0;
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        ref_product  = 0;
        ref_valid    = 0;
        Rst_n        = 1'b0;
        in_valid     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        // Directed sequence with hand-computed expectations.
        tbl.push_back('{1'b0, 1'b1, 7, 3,  0, 0, "reset_edge1"});
        tbl.push_back('{1'b0, 1'b1, 7, 3,  0, 0, "reset_edge2"});
        tbl.push_back('{1'b1, 1'b1, 7, 3, 21, 1, "reset_release"});
        tbl.push_back('{1'b1, 1'b1, 6, 3, 18, 1, "hold_load"});
        tbl.push_back('{1'b1, 1'b0, 1, 1, 18, 0, "hold_1"});
        tbl.push_back('{1'b1, 1'b0, 0, 0, 18, 0, "hold_2"});
        tbl.push_back('{1'b1, 1'b0, 1, 1, 18, 0, "hold_3"});
        tbl.push_back('{1'b1, 1'b1, 7, 3, 21, 1, "carry_7x3"});
        tbl.push_back('{1'b1, 1'b1, 3, 3,  9, 1, "carry_3x3"});
        tbl.push_back('{1'b1, 1'b1, 5, 3, 15, 1, "carry_5x3"});
        tbl.push_back('{1'b0, 1'b1, 5, 3,  0, 0, "midreset"});
        tbl.push_back('{1'b1, 1'b1, 5, 3, 15, 1, "midreset_release"});
        tbl.push_back('{1'b1, 1'b1, 0, 3,  0, 1, "zero_a"});
        tbl.push_back('{1'b1, 1'b1, 7, 0,  0, 1, "zero_b"});
        tbl.push_back('{1'b1, 1'b1, 5, 2, 10, 1, "spot_5x2"});
        tbl.push_back('{1'b1, 1'b0, 7, 3, 10, 0, "idle_hold"});

        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].v, tbl[i].a, tbl[i].b);
            check(tbl[i].name, tbl[i].p, tbl[i].ov);
        end

        // Exhaustive sweep, one result per cycle.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 4; b++) begin
                step(1'b1, 1'b1, a, b);
                check($sformatf("sweep_%0dx%0d", a, b), a * b, 1);
            end
        end

        // Randomized traffic checked against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic r;
            logic v;
            int   a;
            int   b;
            r = ($urandom_range(15) != 0);
            v = 1'($urandom_range(1));
            a = int'($urandom_range(7));
            b = int'($urandom_range(3));
            step(r, v, a, b);
            check($sformatf("rand_%0d", n), ref_product, ref_valid);
            if (ref_product > int'(P_MAX)) begin
                errors++;
                $display("FAIL model_range: product=%0d exceeds %0d", ref_product, P_MAX);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_multiplier_3x2
